// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and
// queues returned instructions with their PCs for the ID stage.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int IW = $clog2(FQ_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW:0] LIMIT = (PW+1)'(FQ_DEPTH);

    logic [31:0]         fetch_pc;
    logic [PW-1:0]       alloc_ptr;
    logic [PW-1:0]       fill_ptr;
    logic [PW-1:0]       head_ptr;
    logic [PW-1:0]       drop_cnt;
    logic [PW-1:0]       count;
    logic [PW-1:0]       unfilled;
    logic [PW:0]         credit;
    logic [31:0]         q_pc    [FQ_DEPTH];
    logic [31:0]         q_instr [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_filled;
    logic [IW-1:0]       a_idx;
    logic [IW-1:0]       f_idx;
    logic [IW-1:0]       h_idx;
    logic                req_fire;
    logic                pop;

    assign count    = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;
    assign credit   = {1'b0, count} + {1'b0, drop_cnt};
    assign a_idx    = alloc_ptr[IW-1:0];
    assign f_idx    = fill_ptr[IW-1:0];
    assign h_idx    = head_ptr[IW-1:0];

    // Stale in-flight responses hold credit until they have been dropped.
    assign imem_req_valid = rst_n && !redirect_valid && (credit < LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid    = q_filled[h_idx];
    assign id_instr    = q_instr[h_idx];
    assign id_pc       = q_pc[h_idx];
    assign id_pc_plus4 = q_pc[h_idx] + 32'd4;
    assign pop         = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            q_filled  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & ~32'd3;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            q_filled  <= '0;
            drop_cnt  <= drop_cnt + unfilled - PW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                q_pc[a_idx]     <= fetch_pc;
                q_filled[a_idx] <= 1'b0;
                alloc_ptr       <= alloc_ptr + PW'(1);
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - PW'(1);
                end else if (unfilled != '0) begin
                    q_instr[f_idx]  <= imem_rsp_data;
                    q_filled[f_idx] <= 1'b1;
                    fill_ptr        <= fill_ptr + PW'(1);
                end
            end
            if (pop) begin
                q_filled[h_idx] <= 1'b0;
                head_ptr        <= head_ptr + PW'(1);
            end
        end
    end

endmodule
